// File: rtl/sync_up_counter_if.sv
// Handshake/bus bundle for sync_up_counter.
// Master drives controls; slave (the counter) drives count and flags.
interface sync_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clear_wrap;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             wrap_sticky;

  modport master (
    output en,
    output load,
    output load_val,
    output clear_wrap,
    input  out,
    input  tc,
    input  wrap,
    input  wrap_sticky
  );

  modport slave (
    input  en,
    input  load,
    input  load_val,
    input  clear_wrap,
    output out,
    output tc,
    output wrap,
    output wrap_sticky
  );
endinterface

// File: rtl/sync_up_counter.sv
// Synchronous modulo-MODULUS up counter with clamped load,
// terminal count for cascading, and wrap pulse / sticky wrap flags.
module sync_up_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic               clk,
  input  logic               rst,
  sync_up_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             wrap_d;
  logic             wrap_q;
  logic             sticky_d;
  logic             sticky_q;
  logic             at_max;

  assign at_max = (out_q == MAX);

  // Next-state: load beats enable; explicit compare drives the wrap.
  always_comb begin
    out_d    = out_q;
    wrap_d   = 1'b0;
    sticky_d = sticky_q;
    if (bus.load) begin
      if (bus.load_val > MAX) begin
        out_d = MAX;
      end else begin
        out_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (at_max) begin
        out_d  = '0;
        wrap_d = 1'b1;
      end else begin
        out_d = out_q + ONE;
      end
    end
    if (wrap_d) begin
      sticky_d = 1'b1;
    end else if (bus.clear_wrap) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; rst clears everything without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.wrap        = wrap_q;
  assign bus.wrap_sticky = sticky_q;
  assign bus.tc          = at_max & bus.en & ~bus.load;

endmodule

// File: tb/tb_sync_up_counter.sv
// Scoreboard bench for sync_up_counter: mod-16, mod-10 and a
// two-digit BCD cascade, checked by per-DUT monitor processes.
module tb_sync_up_counter;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_up_counter_if #(.WIDTH(4)) if16 ();
  sync_up_counter_if #(.WIDTH(4)) if10 ();
  sync_up_counter_if #(.WIDTH(4)) if_lo ();
  sync_up_counter_if #(.WIDTH(4)) if_hi ();

  sync_up_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk (clk),
    .rst (rst),
    .bus (if10)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk (clk),
    .rst (rst),
    .bus (if_lo)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk (clk),
    .rst (rst),
    .bus (if_hi)
  );

  assign if_hi.en         = if_lo.tc;
  assign if_hi.load       = 1'b0;
  assign if_hi.load_val   = 4'd0;
  assign if_hi.clear_wrap = 1'b0;

  typedef struct {
    logic [3:0] out;
    logic       wrap;
    logic       sticky;
    logic       tc;
    logic [3:0] out_hi;
    logic       wrap_hi;
  } exp_t;

  exp_t q16[$];
  exp_t q10[$];
  exp_t qc[$];

  int checks;
  int failures;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t",
               name, act, req, $time);
    end
  endfunction

  task automatic s16(input logic en, input logic ld,
                     input logic [3:0] lv, input logic cw,
                     input logic [3:0] eo, input logic ew,
                     input logic es, input logic et);
    exp_t e;
    if16.en = en;
    if16.load = ld;
    if16.load_val = lv;
    if16.clear_wrap = cw;
    e.out = eo;
    e.wrap = ew;
    e.sticky = es;
    e.tc = et;
    e.out_hi = 4'd0;
    e.wrap_hi = 1'b0;
    q16.push_back(e);
    @(negedge clk);
  endtask

  task automatic s10(input logic en, input logic ld,
                     input logic [3:0] lv, input logic cw,
                     input logic [3:0] eo, input logic ew,
                     input logic es, input logic et);
    exp_t e;
    if10.en = en;
    if10.load = ld;
    if10.load_val = lv;
    if10.clear_wrap = cw;
    e.out = eo;
    e.wrap = ew;
    e.sticky = es;
    e.tc = et;
    e.out_hi = 4'd0;
    e.wrap_hi = 1'b0;
    q10.push_back(e);
    @(negedge clk);
  endtask

  // Monitor for the mod-16 counter.
  always @(posedge clk) begin : mon16
    exp_t e;
    logic t;
    t = if16.tc;
    #1;
    if (q16.size() > 0) begin
      e = q16.pop_front();
      chk("m16_out", 32'(if16.out), 32'(e.out));
      chk("m16_wrap", 32'(if16.wrap), 32'(e.wrap));
      chk("m16_sticky", 32'(if16.wrap_sticky), 32'(e.sticky));
      chk("m16_tc", 32'(t), 32'(e.tc));
    end
  end

  // Monitor for the mod-10 counter.
  always @(posedge clk) begin : mon10
    exp_t e;
    logic t;
    t = if10.tc;
    #1;
    if (q10.size() > 0) begin
      e = q10.pop_front();
      chk("m10_out", 32'(if10.out), 32'(e.out));
      chk("m10_wrap", 32'(if10.wrap), 32'(e.wrap));
      chk("m10_sticky", 32'(if10.wrap_sticky), 32'(e.sticky));
      chk("m10_tc", 32'(t), 32'(e.tc));
    end
  end

  // Monitor for the BCD cascade.
  always @(posedge clk) begin : monc
    exp_t e;
    logic t;
    t = if_lo.tc;
    #1;
    if (qc.size() > 0) begin
      e = qc.pop_front();
      chk("bcd_lo", 32'(if_lo.out), 32'(e.out));
      chk("bcd_hi", 32'(if_hi.out), 32'(e.out_hi));
      chk("bcd_hi_wrap", 32'(if_hi.wrap), 32'(e.wrap_hi));
      chk("bcd_lo_tc", 32'(t), 32'(e.tc));
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int v;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    if16.en = 0; if16.load = 0; if16.load_val = 0; if16.clear_wrap = 0;
    if10.en = 0; if10.load = 0; if10.load_val = 0; if10.clear_wrap = 0;
    if_lo.en = 0; if_lo.load = 0; if_lo.load_val = 0;
    if_lo.clear_wrap = 0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(if16.out), 0);
    chk("rst_wrap", 32'(if16.wrap), 0);
    chk("rst_sticky", 32'(if16.wrap_sticky), 0);
    rst = 1'b0;

    // count to 7, then async reset mid-cycle
    for (int k = 1; k <= 7; k++) s16(1, 0, 0, 0, 4'(k), 0, 0, 0);
    chk("pre_rst_out", 32'(if16.out), 7);
    rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(if16.out), 0);
    chk("async_rst_wrap", 32'(if16.wrap), 0);
    chk("async_rst_sticky", 32'(if16.wrap_sticky), 0);
    for (int k = 0; k < 3; k++) s16(1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // full count 0..15,0,1
    for (int k = 1; k <= 17; k++)
      s16(1, 0, 0, 0, 4'(k % 16), k == 16, k >= 16, k == 16);
    for (int k = 2; k <= 15; k++) s16(1, 0, 0, 0, 4'(k), 0, 1, 0);

    // load beats enable at terminal count
    s16(1, 1, 4'd3, 0, 4'd3, 0, 1, 0);
    for (int k = 0; k < 4; k++) s16(0, 0, 0, 0, 4'd3, 0, 1, 0);

    // wrap coinciding with clear_wrap: set wins
    for (int k = 4; k <= 15; k++) s16(1, 0, 0, 0, 4'(k), 0, 1, 0);
    s16(1, 0, 0, 1, 4'd0, 1, 1, 1);
    s16(0, 0, 0, 1, 4'd0, 0, 0, 0);
    s16(0, 0, 0, 0, 4'd0, 0, 0, 0);

    // mod-10 count, clamped and plain loads
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++)
      s10(1, 0, 0, 0, 4'(k % 10), k == 10, k >= 10, k == 10);
    s10(0, 1, 4'd13, 0, 4'd9, 0, 1, 0);
    s10(0, 1, 4'd5, 0, 4'd5, 0, 1, 0);
    s10(1, 1, 4'd9, 0, 4'd9, 0, 1, 0);
    s10(0, 0, 0, 0, 4'd9, 0, 1, 0);
    s10(1, 0, 0, 0, 4'd0, 1, 1, 1);
    s10(0, 0, 0, 0, 4'd0, 0, 1, 0);

    // two-digit BCD cascade 00..99,00
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      v = k % 100;
      if_lo.en = 1'b1;
      e.out = 4'(v % 10);
      e.out_hi = 4'(v / 10);
      e.wrap_hi = (k == 100);
      e.tc = ((k - 1) % 10 == 9);
      e.wrap = 1'b0;
      e.sticky = 1'b0;
      qc.push_back(e);
      @(negedge clk);
    end
    if_lo.en = 1'b0;

    repeat (2) @(negedge clk);
    chk("queues_drained", 32'(q16.size() + q10.size() + qc.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
